// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM behind a request/ready handshake with WAIT_CYCLES wait states.
module mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq,
   input  logic        MemW,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        AdrErr
);
   localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic we_q, we_d;
   logic [29:0] idx_q, idx_d;
   logic [31:0] wd_q, wd_d;
   logic [31:0] rdata_q;
   logic commit, oob_d;
   logic [31:0] mem [DEPTH_WORDS];
   logic unused_adr;
   assign unused_adr = ^Adr[1:0];
   // commit marks the edge entering DONE; the _d values already hold the access being finished
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      we_d = we_q;
      idx_d = idx_q;
      wd_d = wd_q;
      commit = 1'b0;
      case (state_q)
         IDLE: if (MemReq) begin
            we_d = MemW;
            idx_d = Adr[31:2];
            wd_d = WriteData;
            cnt_d = CNT_INIT;
            state_d = WAIT_CYCLES == 0 ? DONE : BUSY;
            commit = WAIT_CYCLES == 0;
         end
         BUSY: if (cnt_q == 4'd0) begin
            state_d = DONE;
            commit = 1'b1;
         end else cnt_d = cnt_q - 4'd1;
         default: state_d = IDLE;
      endcase
   end
   assign oob_d = idx_d >= DEPTH_IDX;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         we_q <= 1'b0;
         idx_q <= '0;
         wd_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         we_q <= we_d;
         idx_q <= idx_d;
         wd_q <= wd_d;
         if (commit && !we_d) rdata_q <= oob_d ? 32'd0 : mem[idx_d[AW-1:0]];
      end
   end
   always_ff @(posedge clk) begin
      if (commit && we_d && !oob_d && !reset) mem[idx_d[AW-1:0]] <= wd_d;
   end
   assign ReadData = rdata_q;
   assign MemReady = state_q == DONE;
   assign AdrErr = state_q == DONE && idx_q >= DEPTH_IDX;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle ARM datapath's unified instruction/data memory port.
- Serves fetch, load and store requests from the controller side with a configurable number of wait states.
- Signals completion with a one-cycle MemReady pulse so the control FSM can stall in MEMRD/MEMWR/FETCH until the access completes.
- Contains a word-addressed RAM array and its own request-tracking state machine.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words in the internal array; legal word index 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 2: wait states inserted between request acceptance and response; 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemReq  input  1  access request; held by the requester until MemReady.
- MemW  input  1  1 = write, 0 = read; sampled with MemReq.
- Adr  input  32  byte address; word index = Adr[31:2], Adr[1:0] ignored.
- WriteData  input  32  store data; sampled with MemReq.
- ReadData  output  32  registered read data.
- MemReady  output  1  one-cycle completion pulse.
- AdrErr  output  1  out-of-range flag, valid while MemReady=1.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately):
  - state=IDLE, MemReady=0, ReadData=0, AdrErr=0, wait counter=0.
  - Array contents are not reset.
- States:
  - IDLE: if MemReq=1, latch MemW, Adr[31:2] and WriteData. Go to DONE when WAIT_CYCLES=0; otherwise go to BUSY with cnt=WAIT_CYCLES-1.
  - BUSY: if cnt=0 go to DONE, else cnt<=cnt-1. MemReq and inputs are ignored.
  - DONE: MemReady=1 for exactly this cycle, then unconditionally return to IDLE. Inputs are ignored.
- Latency:
  - Request accepted in cycle 0; MemReady high in cycle WAIT_CYCLES+1.
  - Next request is accepted no earlier than cycle WAIT_CYCLES+2, so MemReq held high after MemReady starts a fresh access.
- Array commit and read capture:
  - Write commit and read capture occur on the edge entering DONE, using the latched values.
  - Later changes on Adr/WriteData/MemW have no effect on an in-flight access.
- Read:
  - ReadData <= array[index] on that edge.
  - ReadData holds its value until the next completed read. Writes do not change ReadData.
- Out of range (index >= DEPTH_WORDS):
  - AdrErr=1 during the DONE cycle.
  - A write is suppressed (no array change); a read loads ReadData=0.
  - AdrErr=0 in every other cycle.
- Reset mid-operation: a pending access is dropped, no write commits, and no MemReady is produced.
- MemReq deasserted during BUSY: the access still completes. Requester misuse is not detected.
- Read-after-write to the same address in consecutive accesses returns the new data.

Test Plan:
- Write/read, WAIT_CYCLES=2: write 0xDEADBEEF @Adr 0x10 -> MemReady in cycle 3, AdrErr=0. Then read @0x10 -> MemReady 3 cycles after acceptance, ReadData=0xDEADBEEF.
- Zero wait, WAIT_CYCLES=0: write 0x12345678 @0x04, then read @0x07 (low bits ignored) -> MemReady the cycle after acceptance, ReadData=0x12345678.
- Out of range, DEPTH_WORDS=64: write 0xFFFFFFFF @0x100 -> AdrErr=1 with MemReady. Subsequent read @0x100 -> ReadData=0, AdrErr=1. Read @0x0 -> unchanged prior value.
- Input change in flight: request read @0x10, then switch Adr to 0x20 and MemW=1 during BUSY -> ReadData = word @0x10, and word @0x20 is unmodified.
- Reset mid-access: write 0xAAAA5555 @0x08, assert reset in BUSY -> MemReady, ReadData and AdrErr go to 0 immediately, no MemReady pulse follows, and a later read @0x08 returns the pre-write value.
- Back-to-back: MemReq held high over 3 reads, WAIT_CYCLES=1 -> MemReady pulses exactly every 3 cycles, each pulse is one cycle wide, and ReadData updates on each pulse.
